// File: rtl/izh_pkg.sv
// Shared types and the saturating-add helper for the synaptic weight reader.
package izh_pkg;

   localparam int unsigned WIDTH_DEF      = 8;
   localparam int unsigned NEURON_ADR_DEF = 5;
   localparam int unsigned WEIGHTS_DEF    = 31;
   localparam int unsigned ACC_W_DEF      = 16;
   localparam int unsigned LANES          = (WEIGHTS_DEF + 1) / WIDTH_DEF;
   localparam int unsigned ROWS           = 2 ** (NEURON_ADR_DEF + 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

   typedef struct packed {
      logic               sat;
      logic signed [31:0] sum;
   } sat_sum_t;

   // Operands arrive sign-extended to 32 bits, so the raw sum cannot overflow for acc_w < 31.
   function automatic sat_sum_t sat_add(input logic signed [31:0] acc,
                                        input logic signed [31:0] w,
                                        input int unsigned        acc_w);
      sat_sum_t           r;
      logic signed [31:0] s;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      s     = acc + w;
      hi    = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
      lo    = -hi - 32'sd1;
      r.sat = 1'b0;
      r.sum = s;
      if (s > hi) begin
         r.sat = 1'b1;
         r.sum = hi;
      end else if (s < lo) begin
         r.sat = 1'b1;
         r.sum = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/sat_acc.sv
// One postsynaptic lane: signed saturating accumulator with a sticky clamp flag.
module sat_acc
   import izh_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] w,
   output logic [ACC_W-1:0] acc,
   output logic             sat
);

   sat_sum_t res;

   always_comb begin
      res = sat_add({{(32 - ACC_W){acc[ACC_W-1]}}, acc}, {{(32 - WIDTH){w[WIDTH-1]}}, w}, ACC_W);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc <= '0;
         sat <= 1'b0;
      end else if (clr) begin
         acc <= '0;
         sat <= 1'b0;
      end else if (en) begin
         acc <= res.sum[ACC_W-1:0];
         sat <= sat | res.sat;
      end
   end

endmodule

// File: rtl/synapse_weight_reader.sv
// Sweeps every weight RAM row once per start, accumulating rows whose presynaptic neuron spiked,
// then offers the per-lane currents over a valid/ready handshake.
module synapse_weight_reader
   import izh_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned NEURON_ADR = NEURON_ADR_DEF,
   parameter int unsigned WEIGHTS    = WEIGHTS_DEF,
   parameter int unsigned ACC_W      = ACC_W_DEF
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   start,
   input  logic [2**(NEURON_ADR+1)-1:0]           spikes,
   output logic                                   busy,
   output logic [NEURON_ADR:0]                    dpra,
   input  logic [WEIGHTS:0]                       dpo,
   output logic                                   sum_valid,
   input  logic                                   sum_ready,
   output logic [((WEIGHTS+1)/WIDTH)*ACC_W-1:0]   sum_data,
   output logic [((WEIGHTS+1)/WIDTH)-1:0]         sum_sat
);

   localparam int unsigned NLanes = (WEIGHTS + 1) / WIDTH;
   localparam int unsigned NRows  = 2 ** (NEURON_ADR + 1);
   localparam logic [NEURON_ADR:0] LastRow = '1;

   state_t              state_q, state_d;
   logic [NEURON_ADR:0] dpra_q, dpra_d;
   logic [NRows-1:0]    spike_q, spike_d;
   logic                clr;
   logic                en;

   always_comb begin
      state_d = state_q;
      dpra_d  = dpra_q;
      spike_d = spike_q;
      clr     = 1'b0;
      en      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               spike_d = spikes;
               dpra_d  = '0;
               clr     = 1'b1;
               state_d = StScan;
            end
         end
         StScan: begin
            // dpo is combinational from dpra, so this cycle's row is on the bus now.
            en = spike_q[dpra_q];
            if (dpra_q == LastRow) begin
               state_d = StDone;
            end else begin
               dpra_d = dpra_q + 1'b1;
            end
         end
         StDone: begin
            if (sum_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         dpra_q  <= '0;
         spike_q <= '0;
      end else begin
         state_q <= state_d;
         dpra_q  <= dpra_d;
         spike_q <= spike_d;
      end
   end

   assign busy      = (state_q == StScan);
   assign sum_valid = (state_q == StDone);
   assign dpra      = dpra_q;

   for (genvar k = 0; k < NLanes; k++) begin : g_lane
      sat_acc #(
         .WIDTH(WIDTH),
         .ACC_W(ACC_W)
      ) u_lane (
         .clk  (clk),
         .rst_n(rst_n),
         .clr  (clr),
         .en   (en),
         .w    (dpo[k*WIDTH +: WIDTH]),
         .acc  (sum_data[k*ACC_W +: ACC_W]),
         .sat  (sum_sat[k])
      );
   end

endmodule

// File: tb/tb_synapse_weight_reader.sv
// Directed bench: a 16-bit-accumulator reader and an 8-bit one share a combinational RAM model.
module tb_synapse_weight_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start0, start1;
   logic [63:0] spikes;
   logic        busy0, busy1;
   logic [5:0]  dpra0, dpra1;
   logic [31:0] dpo0, dpo1;
   logic        sum_valid0, sum_valid1;
   logic        sum_ready0, sum_ready1;
   logic [63:0] sum_data0;
   logic [31:0] sum_data1;
   logic [3:0]  sum_sat0, sum_sat1;
   logic [31:0] mem [64];

   int checks = 0;
   int errors = 0;
   int n;
   int sweep_err;
   bit found;

   always #5 clk = ~clk;

   assign dpo0 = mem[dpra0];
   assign dpo1 = mem[dpra1];

   synapse_weight_reader u_dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .spikes(spikes), .busy(busy0), .dpra(dpra0),
      .dpo(dpo0), .sum_valid(sum_valid0), .sum_ready(sum_ready0), .sum_data(sum_data0),
      .sum_sat(sum_sat0)
   );

   synapse_weight_reader #(.ACC_W(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start1), .spikes(spikes), .busy(busy1), .dpra(dpra1),
      .dpo(dpo1), .sum_valid(sum_valid1), .sum_ready(sum_ready1), .sum_data(sum_data1),
      .sum_sat(sum_sat1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 64; i++) mem[i] = {4{i[7:0]}};
   endtask

   task automatic pulse_start(input bit narrow, input logic [63:0] sp);
      @(negedge clk);
      if (narrow) start1 = 1'b1;
      else start0 = 1'b1;
      spikes = sp;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_valid(input bit narrow, output int cnt);
      cnt = 0;
      while (((narrow ? sum_valid1 : sum_valid0) !== 1'b1) && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   task automatic ack(input bit narrow, input string tag);
      @(negedge clk);
      if (narrow) sum_ready1 = 1'b1;
      else sum_ready0 = 1'b1;
      @(negedge clk);
      sum_ready0 = 1'b0;
      sum_ready1 = 1'b0;
      chk(tag, narrow ? sum_valid1 : sum_valid0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; spikes = '0;
      sum_ready0 = 1'b0; sum_ready1 = 1'b0;
      fill_ramp();
      repeat (2) @(negedge clk);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_dpra", dpra0, 6'd0);
      chk("rst_valid", sum_valid0, 1'b0);
      chk("rst_data", sum_data0, 64'd0);
      chk("rst_sat", sum_sat0, 4'd0);
      rst_n = 1'b1;

      // Ramp rows, every neuron spiking: each lane sums 0..63.
      pulse_start(1'b0, '1);
      chk("t1_busy", busy0, 1'b1);
      wait_valid(1'b0, n);
      chk("t1_latency", n, 64);
      chk("t1_data", sum_data0, {4{16'd2016}});
      chk("t1_sat", sum_sat0, 4'd0);
      chk("t1_busy_done", busy0, 1'b0);
      ack(1'b0, "t1_ack");
      chk("t1_data_kept", sum_data0, {4{16'd2016}});

      // Single spiking row with mixed-sign weights.
      mem[5] = {8'h80, 8'h7F, 8'hFF, 8'h01};
      pulse_start(1'b0, 64'd1 << 5);
      wait_valid(1'b0, n);
      chk("t2_latency", n, 64);
      chk("t2_data", sum_data0, {16'hFF80, 16'h007F, 16'hFFFF, 16'h0001});
      chk("t2_sat", sum_sat0, 4'd0);
      ack(1'b0, "t2_ack");

      // No spikes: full sweep, address walks every row.
      pulse_start(1'b0, 64'd0);
      sweep_err = 0;
      for (int i = 0; i < 64; i++) begin
         if (dpra0 !== i[5:0] || busy0 !== 1'b1) sweep_err++;
         @(negedge clk);
      end
      chk("t6_sweep", sweep_err, 0);
      chk("t6_valid", sum_valid0, 1'b1);
      chk("t6_data", sum_data0, 64'd0);
      chk("t6_sat", sum_sat0, 4'd0);
      ack(1'b0, "t6_ack");

      // 8-bit accumulators clamp at both rails.
      for (int i = 0; i < 64; i++) mem[i] = 32'h7F7F_7F7F;
      pulse_start(1'b1, '1);
      wait_valid(1'b1, n);
      chk("t3_latency", n, 64);
      chk("t3_pos_data", sum_data1, 32'h7F7F_7F7F);
      chk("t3_pos_sat", sum_sat1, 4'hF);
      ack(1'b1, "t3_pos_ack");
      for (int i = 0; i < 64; i++) mem[i] = 32'h8080_8080;
      pulse_start(1'b1, '1);
      wait_valid(1'b1, n);
      chk("t3_neg_data", sum_data1, 32'h8080_8080);
      chk("t3_neg_sat", sum_sat1, 4'hF);
      ack(1'b1, "t3_neg_ack");

      // Starts during SCAN and DONE are ignored; result held while ready is low.
      fill_ramp();
      pulse_start(1'b0, 64'h0000_0000_FFFF_FFFF);
      start0 = 1'b1; spikes = '1;
      @(negedge clk);
      start0 = 1'b0;
      wait_valid(1'b0, n);
      chk("t4_latency", n, 63);
      chk("t4_data", sum_data0, {4{16'd496}});
      for (int i = 0; i < 10; i++) begin
         start0 = (i == 3);
         @(negedge clk);
      end
      start0 = 1'b0;
      chk("t4_held_valid", sum_valid0, 1'b1);
      chk("t4_held_data", sum_data0, {4{16'd496}});
      chk("t4_no_rerun", busy0, 1'b0);
      ack(1'b0, "t4_ack");
      pulse_start(1'b0, 64'd1 << 63);
      wait_valid(1'b0, n);
      chk("t4_fresh_latency", n, 64);
      chk("t4_fresh_data", sum_data0, {4{16'd63}});
      ack(1'b0, "t4_fresh_ack");

      // Reset in the middle of a pass.
      pulse_start(1'b0, '1);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (dpra0 === 6'd30) found = 1'b1;
         else @(negedge clk);
      end
      chk("t5_row30", found, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("t5_busy", busy0, 1'b0);
      chk("t5_dpra", dpra0, 6'd0);
      chk("t5_valid", sum_valid0, 1'b0);
      chk("t5_data", sum_data0, 64'd0);
      chk("t5_sat", sum_sat0, 4'd0);
      pulse_start(1'b0, '1);
      wait_valid(1'b0, n);
      chk("t5_latency", n, 64);
      chk("t5_data_after", sum_data0, {4{16'd2016}});
      ack(1'b0, "t5_ack");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
